// File: rtl/pll_lock_monitor.sv
// Reference-clock supervisor for the PLL. It sequences PLL reset, lock wait, stability
// qualification, retries on timeout and reports ready/fail/lock-loss. Optional macro: PLLMON_AUTO_RECOVER_EN.
module pll_lock_monitor #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 27000,
   parameter int unsigned STABLE_CYCLES = 256,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned CNT_W         = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_lock,
   output logic       o_pll_rst,
   output logic       o_ready,
   output logic       o_fail,
   output logic [3:0] o_retry_cnt,
   output logic [7:0] o_lost_cnt
);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d;
   logic [7:0]       lost_q, lost_d;
   logic             pll_rst_q, pll_rst_d;
   logic             ready_q, ready_d;
   logic             fail_q, fail_d;
   logic             sync1_q, sync2_q;
   logic             lock_s;

   // Two-flop synchronizer for the asynchronous PLL lock.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= i_lock;
         sync2_q <= sync1_q;
      end
   end

   assign lock_s = sync2_q;

   // State register, shared counter, status counters and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_RESET_PLL;
         cnt_q     <= CNT_ZERO;
         retry_q   <= 4'd0;
         lost_q    <= 8'd0;
         pll_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         lost_q    <= lost_d;
         pll_rst_q <= pll_rst_d;
         ready_q   <= ready_d;
         fail_q    <= fail_d;
      end
   end

   // Next-state and counter update logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      lost_d  = lost_q;
      case (state_q)
         S_RESET_PLL: begin
            if (cnt_q == RST_LAST) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_WAIT_LOCK: begin
            if (lock_s) begin
               state_d = S_STABLE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == LOCK_LAST) begin
               cnt_d = CNT_ZERO;
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 4'd1;
                  state_d = S_RESET_PLL;
               end else begin
                  state_d = S_FAIL;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_STABLE: begin
            // A dropout restarts the lock timeout without costing a retry.
            if (!lock_s) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RUN;
               cnt_d   = CNT_ZERO;
               retry_d = 4'd0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_RUN: begin
            if (!lock_s) begin
               lost_d = (lost_q == 8'hFF) ? lost_q : (lost_q + 8'd1);
               cnt_d  = CNT_ZERO;
`ifdef PLLMON_AUTO_RECOVER_EN
               state_d = S_RESET_PLL;
`else
               state_d = S_WAIT_LOCK;
`endif
            end else begin
               state_d = S_RUN;
            end
         end
         S_FAIL: begin
            state_d = S_FAIL;
         end
         default: begin
            state_d = S_RESET_PLL;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Output decode from the next state so every output is a plain flop.
   always_comb begin
      pll_rst_d = 1'b0;
      ready_d   = 1'b0;
      fail_d    = 1'b0;
      case (state_d)
         S_RESET_PLL: pll_rst_d = 1'b1;
         S_WAIT_LOCK: pll_rst_d = 1'b0;
         S_STABLE:    pll_rst_d = 1'b0;
         S_RUN:       ready_d   = 1'b1;
         S_FAIL: begin
            pll_rst_d = 1'b1;
            fail_d    = 1'b1;
         end
         default:     pll_rst_d = 1'b1;
      endcase
   end

   assign o_pll_rst   = pll_rst_q;
   assign o_ready     = ready_q;
   assign o_fail      = fail_q;
   assign o_retry_cnt = retry_q;
   assign o_lost_cnt  = lost_q;

endmodule
